// File: rtl/branch_predictor_pkg.sv
// Shared constants for the branch predictor and the pipeline's hazard/flush logic.
package branch_predictor_pkg;

  // Two-bit saturating counter encodings; bit 1 is the taken prediction.
  typedef enum logic [1:0] {
    SNT = 2'b00,  // strong not-taken
    WNT = 2'b01,  // weak not-taken
    WT  = 2'b10,  // weak taken
    ST  = 2'b11   // strong taken
  } ctr_state_e;

  // Every table entry starts here so the first outcome flips it.
  localparam logic [1:0] CTR_RESET = WNT;

  // Hazard / flush constants shared with the pipeline control.
  // A resolved mispredict in EX kills the younger IF and ID instructions.
  localparam int unsigned FLUSH_STAGES = 2;

  typedef enum logic [1:0] {
    HZ_NONE  = 2'b00,
    HZ_STALL = 2'b01,
    HZ_FLUSH = 2'b10
  } hazard_e;

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// Next-state logic for one two-bit saturating counter.
module sat_counter2
  import branch_predictor_pkg::*;
(
  input  logic [1:0] cur_state,
  input  logic       taken,
  output logic [1:0] next_state
);

  // Step towards the outcome, holding at either end of the range.
  always_comb begin
    next_state = cur_state;
    case (cur_state)
      SNT:     next_state = taken ? WNT : SNT;
      WNT:     next_state = taken ? WT  : SNT;
      WT:      next_state = taken ? ST  : WNT;
      ST:      next_state = taken ? ST  : WT;
      default: next_state = CTR_RESET;
    endcase
  end

endmodule

// File: rtl/branch_predictor.sv
// Bimodal branch predictor: a table of two-bit counters indexed by PC bits,
// read combinationally in IF and trained by resolved branches in EX, with
// saturating branch / mispredict statistics.
//
// Update interface: upd_valid_i qualifies upd_pc_i, upd_taken_i and
// upd_pred_i in the same cycle. There is no ready; the predictor accepts an
// update on every clock edge where upd_valid_i is high.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int IDX_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [31:0]      if_pc_i,
  output logic             pred_taken_o,
  input  logic             upd_valid_i,
  input  logic [31:0]      upd_pc_i,
  input  logic             upd_taken_i,
  input  logic             upd_pred_i,
  output logic             mispredict_o,
  output logic [CNT_W-1:0] branch_cnt_o,
  output logic [CNT_W-1:0] miss_cnt_o
);

  localparam int ENTRIES = 1 << IDX_W;

  logic [1:0]       tbl [ENTRIES];
  logic [IDX_W-1:0] if_idx;
  logic [IDX_W-1:0] upd_idx;
  logic [1:0]       upd_next;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] miss_cnt;

  // Upper PC bits and the byte offset deliberately do not take part in
  // indexing: aliasing PCs share an entry and there is no tag.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{if_pc_i[31:IDX_W+2], if_pc_i[1:0],
                            upd_pc_i[31:IDX_W+2], upd_pc_i[1:0]};

  assign if_idx  = if_pc_i[IDX_W+1:2];
  assign upd_idx = upd_pc_i[IDX_W+1:2];

  // Read reflects the registered table, so a same-cycle update to the same
  // entry only becomes visible on the following cycle.
  assign pred_taken_o = tbl[if_idx][1];

  // Purely input-driven so the flush request stays meaningful during reset.
  assign mispredict_o = upd_valid_i & (upd_taken_i ^ upd_pred_i);

  // Single shared update path for the entry named by the EX branch.
  sat_counter2 u_sat (
    .cur_state  (tbl[upd_idx]),
    .taken      (upd_taken_i),
    .next_state (upd_next)
  );

  // Prediction table: reset to weak not-taken, train on valid updates.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        tbl[i] <= CTR_RESET;
      end
    end else if (upd_valid_i) begin
      tbl[upd_idx] <= upd_next;
    end
  end

  // Statistics counters, each holding at all-ones instead of wrapping.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      branch_cnt <= '0;
      miss_cnt   <= '0;
    end else begin
      if (upd_valid_i && (branch_cnt != {CNT_W{1'b1}})) begin
        branch_cnt <= branch_cnt + CNT_W'(1);
      end
      if (mispredict_o && (miss_cnt != {CNT_W{1'b1}})) begin
        miss_cnt <= miss_cnt + CNT_W'(1);
      end
    end
  end

  assign branch_cnt_o = branch_cnt;
  assign miss_cnt_o   = miss_cnt;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed testbench for branch_predictor: a default-width instance and a
// CNT_W=4 instance share the same stimulus.
module tb_branch_predictor;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [31:0] if_pc_i = '0;
  logic        upd_valid_i = 1'b0;
  logic [31:0] upd_pc_i = '0;
  logic        upd_taken_i = 1'b0;
  logic        upd_pred_i = 1'b0;

  logic        pred_taken_o;
  logic        mispredict_o;
  logic [15:0] branch_cnt_o;
  logic [15:0] miss_cnt_o;

  logic        pred4;
  logic        mis4;
  logic [3:0]  branch4;
  logic [3:0]  miss4;

  int n_cmp = 0;
  int n_err = 0;

  branch_predictor #(.IDX_W(4), .CNT_W(16)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .if_pc_i      (if_pc_i),
    .pred_taken_o (pred_taken_o),
    .upd_valid_i  (upd_valid_i),
    .upd_pc_i     (upd_pc_i),
    .upd_taken_i  (upd_taken_i),
    .upd_pred_i   (upd_pred_i),
    .mispredict_o (mispredict_o),
    .branch_cnt_o (branch_cnt_o),
    .miss_cnt_o   (miss_cnt_o)
  );

  branch_predictor #(.IDX_W(4), .CNT_W(4)) dut4 (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .if_pc_i      (if_pc_i),
    .pred_taken_o (pred4),
    .upd_valid_i  (upd_valid_i),
    .upd_pc_i     (upd_pc_i),
    .upd_taken_i  (upd_taken_i),
    .upd_pred_i   (upd_pred_i),
    .mispredict_o (mis4),
    .branch_cnt_o (branch4),
    .miss_cnt_o   (miss4)
  );

  // Clock
  always #5 clk_i = ~clk_i;

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk_i);
    upd_valid_i = 1'b0;
    rst_i = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;
  endtask

  // One update across one rising edge; valid drops just after the edge.
  task automatic do_update(input logic [31:0] pc, input logic tk, input logic pr);
    @(negedge clk_i);
    upd_valid_i = 1'b1;
    upd_pc_i    = pc;
    upd_taken_i = tk;
    upd_pred_i  = pr;
    @(posedge clk_i);
    #1;
    upd_valid_i = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk_i);
    rst_i = 1'b0;
    if_pc_i = 32'h40;
    #1;
    n_cmp++;
    if (pred_taken_o !== 1'b0) begin
      n_err++; $display("FAIL reset_pred_during: got %0b want 0", pred_taken_o);
    end
    n_cmp++;
    if (branch_cnt_o !== 16'd0 || miss_cnt_o !== 16'd0) begin
      n_err++; $display("FAIL reset_cnt_during: got %0d/%0d want 0/0", branch_cnt_o, miss_cnt_o);
    end
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    n_cmp++;
    if (pred_taken_o !== 1'b0) begin
      n_err++; $display("FAIL reset_pred_after: got %0b want 0", pred_taken_o);
    end
    n_cmp++;
    if (mispredict_o !== 1'b0) begin
      n_err++; $display("FAIL reset_mispredict: got %0b want 0", mispredict_o);
    end
  endtask

  task automatic test_train_taken();
    logic [2:0] prs;
    logic [2:0] exp_mis;
    prs     = 3'b110;  // bit i = carried prediction of update i
    exp_mis = 3'b001;
    do_reset();
    if_pc_i = 32'h40;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      upd_valid_i = 1'b1;
      upd_pc_i    = 32'h40;
      upd_taken_i = 1'b1;
      upd_pred_i  = prs[i];
      #1;
      n_cmp++;
      if (mispredict_o !== exp_mis[i]) begin
        n_err++; $display("FAIL taken_mispredict[%0d]: got %0b want %0b", i, mispredict_o, exp_mis[i]);
      end
      @(posedge clk_i);
      #1;
      upd_valid_i = 1'b0;
      #1;
      n_cmp++;
      if (pred_taken_o !== 1'b1) begin
        n_err++; $display("FAIL taken_pred[%0d]: got %0b want 1", i, pred_taken_o);
      end
    end
    n_cmp++;
    if (branch_cnt_o !== 16'd3 || miss_cnt_o !== 16'd1) begin
      n_err++; $display("FAIL taken_stats: got %0d/%0d want 3/1", branch_cnt_o, miss_cnt_o);
    end
  endtask

  // Continues from the strong-taken state left by test_train_taken.
  task automatic test_train_not_taken();
    logic [1:0] exp_pred;
    exp_pred = 2'b01;  // after first update 1, after second 0
    if_pc_i = 32'h40;
    #1;
    n_cmp++;
    if (pred_taken_o !== 1'b1) begin
      n_err++; $display("FAIL nt_pred_start: got %0b want 1", pred_taken_o);
    end
    for (int i = 0; i < 2; i++) begin
      do_update(32'h40, 1'b0, 1'b1);
      #1;
      n_cmp++;
      if (pred_taken_o !== exp_pred[i]) begin
        n_err++; $display("FAIL nt_pred[%0d]: got %0b want %0b", i, pred_taken_o, exp_pred[i]);
      end
    end
    n_cmp++;
    if (branch_cnt_o !== 16'd5 || miss_cnt_o !== 16'd3) begin
      n_err++; $display("FAIL nt_stats: got %0d/%0d want 5/3", branch_cnt_o, miss_cnt_o);
    end
  endtask

  task automatic test_same_cycle();
    do_reset();
    @(negedge clk_i);
    if_pc_i     = 32'h44;
    upd_valid_i = 1'b1;
    upd_pc_i    = 32'h44;
    upd_taken_i = 1'b1;
    upd_pred_i  = 1'b0;
    #1;
    n_cmp++;
    if (pred_taken_o !== 1'b0) begin
      n_err++; $display("FAIL same_cycle_old: got %0b want 0", pred_taken_o);
    end
    @(posedge clk_i);
    #1;
    upd_valid_i = 1'b0;
    #1;
    n_cmp++;
    if (pred_taken_o !== 1'b1) begin
      n_err++; $display("FAIL same_cycle_new: got %0b want 1", pred_taken_o);
    end
  endtask

  task automatic test_alias();
    do_reset();
    do_update(32'h04, 1'b1, 1'b0);
    do_update(32'h04, 1'b1, 1'b1);
    if_pc_i = 32'h44;
    #1;
    n_cmp++;
    if (pred_taken_o !== 1'b1) begin
      n_err++; $display("FAIL alias_0x44: got %0b want 1", pred_taken_o);
    end
    if_pc_i = 32'h47;
    #1;
    n_cmp++;
    if (pred_taken_o !== 1'b1) begin
      n_err++; $display("FAIL alias_low_bits: got %0b want 1", pred_taken_o);
    end
    if_pc_i = 32'h08;
    #1;
    n_cmp++;
    if (pred_taken_o !== 1'b0) begin
      n_err++; $display("FAIL alias_neighbour: got %0b want 0", pred_taken_o);
    end
  endtask

  task automatic test_hold_and_low_sat();
    do_reset();
    if_pc_i = 32'h10;
    @(negedge clk_i);
    upd_valid_i = 1'b0;
    upd_pc_i    = 32'h10;
    upd_taken_i = 1'b1;
    upd_pred_i  = 1'b0;
    #1;
    n_cmp++;
    if (mispredict_o !== 1'b0) begin
      n_err++; $display("FAIL idle_mispredict: got %0b want 0", mispredict_o);
    end
    repeat (3) @(negedge clk_i);
    n_cmp++;
    if (pred_taken_o !== 1'b0 || branch_cnt_o !== 16'd0 || miss_cnt_o !== 16'd0) begin
      n_err++; $display("FAIL idle_hold: got pred %0b cnt %0d/%0d want 0 0/0",
                        pred_taken_o, branch_cnt_o, miss_cnt_o);
    end
    // 01 -> 00 -> 00, then taken 00 -> 01 (pred 0), taken 01 -> 10 (pred 1)
    do_update(32'h10, 1'b0, 1'b0);
    do_update(32'h10, 1'b0, 1'b0);
    do_update(32'h10, 1'b1, 1'b0);
    #1;
    n_cmp++;
    if (pred_taken_o !== 1'b0) begin
      n_err++; $display("FAIL low_sat_step1: got %0b want 0", pred_taken_o);
    end
    do_update(32'h10, 1'b1, 1'b0);
    #1;
    n_cmp++;
    if (pred_taken_o !== 1'b1) begin
      n_err++; $display("FAIL low_sat_step2: got %0b want 1", pred_taken_o);
    end
    n_cmp++;
    if (branch_cnt_o !== 16'd4 || miss_cnt_o !== 16'd2) begin
      n_err++; $display("FAIL low_sat_stats: got %0d/%0d want 4/2", branch_cnt_o, miss_cnt_o);
    end
  endtask

  task automatic test_stat_saturation();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      do_update(32'h20, 1'b1, 1'b0);
    end
    n_cmp++;
    if (branch4 !== 4'd15 || miss4 !== 4'd15) begin
      n_err++; $display("FAIL cnt4_saturate: got %0d/%0d want 15/15", branch4, miss4);
    end
    n_cmp++;
    if (branch_cnt_o !== 16'd20 || miss_cnt_o !== 16'd20) begin
      n_err++; $display("FAIL cnt16_count: got %0d/%0d want 20/20", branch_cnt_o, miss_cnt_o);
    end
    // Reset lands mid-cycle while an update is pending; the update is lost.
    if_pc_i = 32'h20;
    @(negedge clk_i);
    upd_valid_i = 1'b1;
    upd_pc_i    = 32'h30;
    upd_taken_i = 1'b1;
    upd_pred_i  = 1'b0;
    #2;
    rst_i = 1'b0;
    #1;
    n_cmp++;
    if (branch4 !== 4'd0 || miss4 !== 4'd0 || branch_cnt_o !== 16'd0 || miss_cnt_o !== 16'd0) begin
      n_err++; $display("FAIL async_reset_cnt: got %0d/%0d %0d/%0d want all 0",
                        branch4, miss4, branch_cnt_o, miss_cnt_o);
    end
    n_cmp++;
    if (pred_taken_o !== 1'b0) begin
      n_err++; $display("FAIL async_reset_pred: got %0b want 0", pred_taken_o);
    end
    n_cmp++;
    if (mispredict_o !== 1'b1) begin
      n_err++; $display("FAIL reset_mispredict_live: got %0b want 1", mispredict_o);
    end
    @(negedge clk_i);
    upd_valid_i = 1'b0;
    rst_i = 1'b1;
    if_pc_i = 32'h30;
    #1;
    n_cmp++;
    if (pred_taken_o !== 1'b0 || branch_cnt_o !== 16'd0) begin
      n_err++; $display("FAIL reset_update_lost: got pred %0b cnt %0d want 0 0",
                        pred_taken_o, branch_cnt_o);
    end
    // One taken update per entry moves weak-NT to weak-T.
    for (int e = 0; e < 16; e++) begin
      do_update(32'(e * 4), 1'b1, 1'b0);
      if_pc_i = 32'(e * 4);
      #1;
      n_cmp++;
      if (pred_taken_o !== 1'b1) begin
        n_err++; $display("FAIL entry_reset_wnt[%0d]: got %0b want 1", e, pred_taken_o);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_train_taken();
    test_train_not_taken();
    test_same_cycle();
    test_alias();
    test_hold_and_low_sat();
    test_stat_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter IDX_W, default 4, meaning log2 of the table entry count (16 entries).
REQ-002 SHALL have parameter CNT_W, default 16, meaning width of the statistics counters.
REQ-003 clk_i  input  1  clock; all state updates on the rising edge.
REQ-004 rst_i  input  1  reset; one clock, reset is asynchronous and active-low.
REQ-005 if_pc_i  input  32  PC of the instruction in IF.
REQ-006 pred_taken_o  output  1  prediction for if_pc_i.
REQ-007 upd_valid_i  input  1  a resolved branch is present in EX this cycle.
REQ-008 upd_pc_i  input  32  PC of the resolved branch.
REQ-009 upd_taken_i  input  1  actual outcome, driven by the branch condition select mux.
REQ-010 upd_pred_i  input  1  prediction carried down the pipeline with that branch.
REQ-011 mispredict_o  output  1  flush request for the current EX branch.
REQ-012 branch_cnt_o  output  CNT_W  resolved-branch count.
REQ-013 miss_cnt_o  output  CNT_W  mispredict count.

Function
REQ-014 SHALL hold 2**IDX_W two-bit saturating counters: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
REQ-015 SHALL form the index as pc[IDX_W+1:2]; pc[1:0] is ignored.
REQ-016 SHALL drive pred_taken_o combinationally as bit 1 of the counter indexed by if_pc_i, with zero-cycle latency.
REQ-017 SHALL, on a clock edge with upd_valid_i=1, increment the counter at upd_pc_i's index when upd_taken_i=1 and decrement it when upd_taken_i=0.
REQ-018 SHALL saturate counters: 11 stays 11 on taken, and 00 stays 00 on not-taken.
REQ-019 SHALL leave all state unchanged on cycles with upd_valid_i=0.
REQ-020 SHALL drive mispredict_o combinationally as upd_valid_i & (upd_taken_i ^ upd_pred_i).
REQ-021 SHALL return the pre-update (old) counter on pred_taken_o when IF and EX hit the same index in one cycle; the new value is visible from the next cycle.
REQ-022 SHALL increment branch_cnt_o on each upd_valid_i=1 edge, and SHALL increment miss_cnt_o on each edge where mispredict_o=1.
REQ-023 SHALL saturate both statistics counters at all-ones, with no wrap.
REQ-024 SHALL keep PCs with different upper bits that alias to one index sharing that entry, with no tag check.

Reset
REQ-025 SHALL asynchronously set all table counters to 01 (weak-NT) while rst_i=0.
REQ-026 SHALL clear branch_cnt_o and miss_cnt_o to 0 while rst_i=0.
REQ-027 SHALL hold pred_taken_o at 0 during reset, since it follows from the counter reset.
REQ-028 SHALL resolve reset asserted mid-update in favour of reset, with the update lost.
REQ-029 SHALL drive mispredict_o from inputs only, so it remains valid during reset.

Structure
REQ-030 SHALL place counter state encodings (SNT/WNT/WT/ST) and the reset value WNT in a shared package with the pipeline's hazard/flush constants.
REQ-031 SHALL use one sub-module, sat_counter2, computing the next 2-bit state from the current state and the taken bit; the table instantiates the update path once.

Verification
REQ-032 Reset then if_pc_i=0x40 -> pred_taken_o=0; counters 0.
REQ-033 Three updates pc=0x40 taken=1 pred=0,1,1 -> counter 01->10->11->11; pred_taken_o for 0x40 =1 after the first edge; mispredict_o=1 only on the first; miss_cnt_o=1, branch_cnt_o=3.
REQ-034 Counter at 11, then updates pc=0x40 taken=0 twice -> 10 then 01; pred_taken_o goes 1,1,0.
REQ-035 Same-cycle if_pc_i=0x44, upd_pc_i=0x44 taken=1 from 01 -> pred_taken_o=0 that cycle, 1 the next.
REQ-036 Aliasing: update pc=0x04 taken twice, then read pc=0x44 -> pred_taken_o=1.
REQ-037 CNT_W=4, 20 mispredicting updates -> both counters 15; then rst_i low mid-cycle -> immediate 0 and all entries 01.
